// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/funct
// fields, ALU operation codes and datapath mux select codes.
package mcpu_pkg;

   typedef enum logic [4:0] {
      S_IF       = 5'd0,
      S_ID       = 5'd1,
      S_MEM_ADDR = 5'd2,
      S_MEM_RD   = 5'd3,
      S_WB_LW    = 5'd4,
      S_MEM_WR   = 5'd5,
      S_EX_R     = 5'd6,
      S_WB_R     = 5'd7,
      S_BR       = 5'd8,
      S_J        = 5'd9,
      S_JAL      = 5'd10,
      S_JR       = 5'd11,
      S_JALR     = 5'd12,
      S_EX_I     = 5'd13,
      S_WB_I     = 5'd14,
      S_ILLEGAL  = 5'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_RS     = 2'b11;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BOFF  = 2'b11;

   localparam logic [1:0] DST_RT     = 2'b00;
   localparam logic [1:0] DST_RD     = 2'b01;
   localparam logic [1:0] DST_RA     = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic [1:0] M2R_LUI    = 2'b11;

   typedef struct packed {
      state_t     dispatch;   // state that follows ID
      logic [2:0] alu_ctrl;   // operation for EX_R / EX_I
      logic       ext_zero;
      logic       is_store;
      logic       is_bne;
      logic       is_lui;
   } dec_t;

endpackage

// File: rtl/mcpu_decode.sv
// Combinational instruction classifier: maps OPcode/Fun onto the state that
// follows ID plus the ALU operation and per-instruction qualifiers.
module mcpu_decode
   import mcpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] fun,
   output dec_t       dec
);

   always_comb begin
      dec          = '0;
      dec.dispatch = S_ILLEGAL;
      dec.alu_ctrl = ALU_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            dec.dispatch = S_EX_R;
            case (fun)
               FN_ADD:  dec.alu_ctrl = ALU_ADD;
               FN_SUB:  dec.alu_ctrl = ALU_SUB;
               FN_AND:  dec.alu_ctrl = ALU_AND;
               FN_OR:   dec.alu_ctrl = ALU_OR;
               FN_SLT:  dec.alu_ctrl = ALU_SLT;
               FN_NOR:  dec.alu_ctrl = ALU_NOR;
               FN_SRL:  dec.alu_ctrl = ALU_SRL;
               FN_XOR:  dec.alu_ctrl = ALU_XOR;
               FN_JR:   dec.dispatch = S_JR;
               FN_JALR: dec.dispatch = S_JALR;
               default: dec.dispatch = S_ILLEGAL;
            endcase
         end
         OP_LW:   dec.dispatch = S_MEM_ADDR;
         OP_SW: begin
            dec.dispatch = S_MEM_ADDR;
            dec.is_store = 1'b1;
         end
         OP_BEQ:  dec.dispatch = S_BR;
         OP_BNE: begin
            dec.dispatch = S_BR;
            dec.is_bne   = 1'b1;
         end
         OP_J:    dec.dispatch = S_J;
         OP_JAL:  dec.dispatch = S_JAL;
         OP_ADDI: dec.dispatch = S_EX_I;
         OP_SLTI: begin
            dec.dispatch = S_EX_I;
            dec.alu_ctrl = ALU_SLT;
         end
         // logical immediates use the zero-extended field
         OP_ANDI: begin
            dec.dispatch = S_EX_I;
            dec.alu_ctrl = ALU_AND;
            dec.ext_zero = 1'b1;
         end
         OP_ORI: begin
            dec.dispatch = S_EX_I;
            dec.alu_ctrl = ALU_OR;
            dec.ext_zero = 1'b1;
         end
         OP_XORI: begin
            dec.dispatch = S_EX_I;
            dec.alu_ctrl = ALU_XOR;
            dec.ext_zero = 1'b1;
         end
         OP_LUI: begin
            dec.dispatch = S_EX_I;
            dec.is_lui   = 1'b1;
         end
         default: dec.dispatch = S_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM: state register plus Moore output decode, with
// fetch/branch write enables qualified by MIO_ready and zero.
module mcpu_ctrl
   import mcpu_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OPcode,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       CPU_MIO,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ExtZero,
   output logic [2:0] ALU_Control,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       RegWrite,
   output logic       illegal,
   output logic [4:0] state
);

   state_t state_q, state_d;
   dec_t   dec;

   mcpu_decode u_decode (
      .opcode (OPcode),
      .fun    (Fun),
      .dec    (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IF;
      else        state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d     = state_q;
      CPU_MIO     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCSource    = PCS_ALU;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      ExtZero     = 1'b0;
      ALU_Control = ALU_ADD;
      RegDst      = DST_RT;
      MemtoReg    = M2R_ALUOUT;
      RegWrite    = 1'b0;
      illegal     = 1'b0;

      unique case (state_q)
         S_IF: begin
            CPU_MIO = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            PCWrite = MIO_ready;
            IRWrite = MIO_ready;
            if (MIO_ready) state_d = S_ID;
         end
         S_ID: begin
            ALUSrcB = SRCB_BOFF;
            state_d = dec.dispatch;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = dec.is_store ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            CPU_MIO = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MIO_ready) state_d = S_WB_LW;
         end
         S_WB_LW: begin
            MemtoReg = M2R_MDR;
            RegWrite = 1'b1;
            state_d  = S_IF;
         end
         S_MEM_WR: begin
            CPU_MIO  = 1'b1;
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (MIO_ready) state_d = S_IF;
         end
         S_EX_R: begin
            ALUSrcA     = 1'b1;
            ALU_Control = dec.alu_ctrl;
            state_d     = S_WB_R;
         end
         S_WB_R: begin
            RegDst   = DST_RD;
            RegWrite = 1'b1;
            state_d  = S_IF;
         end
         S_BR: begin
            ALUSrcA     = 1'b1;
            ALU_Control = ALU_SUB;
            PCSource    = PCS_ALUOUT;
            PCWrite     = dec.is_bne ? ~zero : zero;
            state_d     = S_IF;
         end
         S_J: begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
            state_d  = S_IF;
         end
         // PC already holds PC+4 here, so it is the link value
         S_JAL: begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
            state_d  = S_IF;
         end
         S_JR: begin
            PCSource = PCS_RS;
            PCWrite  = 1'b1;
            state_d  = S_IF;
         end
         S_JALR: begin
            PCSource = PCS_RS;
            PCWrite  = 1'b1;
            RegDst   = DST_RD;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
            state_d  = S_IF;
         end
         S_EX_I: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = SRCB_IMM;
            ALU_Control = dec.alu_ctrl;
            ExtZero     = dec.ext_zero;
            state_d     = S_WB_I;
         end
         S_WB_I: begin
            RegWrite = 1'b1;
            MemtoReg = dec.is_lui ? M2R_LUI : M2R_ALUOUT;
            state_d  = S_IF;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? S_ILLEGAL : S_IF;
         end
         default: state_d = S_IF;
      endcase

      // strobes must drop the instant reset asserts, even mid-access
      if (!rst_n) begin
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Randomized scoreboard bench for mcpu_ctrl: a per-instruction reference model
// queues the expected output vector of every cycle; a monitor pops and compares.
module tb_mcpu_ctrl;

   typedef struct packed {
      logic [4:0] st;
      logic       cpu_mio, mem_read, mem_write, iord, ir_write, pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [2:0] alu;
      logic [1:0] reg_dst, mem_to_reg;
      logic       reg_write, illegal;
   } vec_t;

   typedef enum int {K_R, K_JR, K_JALR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_I, K_ILL} kind_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fun;
      kind_t      k;
      logic [2:0] alu;
      logic       ez;
      logic       lui;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] OPcode = '0;
   logic [5:0] Fun = '0;
   logic       zero = 1'b0;
   logic       MIO_ready = 1'b1;
   logic       CPU_MIO, MemRead, MemWrite, IorD, IRWrite, PCWrite;
   logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
   logic       ALUSrcA, ExtZero, RegWrite, illegal;
   logic [2:0] ALU_Control;
   logic [4:0] state;

   mcpu_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun(Fun), .zero(zero),
      .MIO_ready(MIO_ready), .CPU_MIO(CPU_MIO), .MemRead(MemRead),
      .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ExtZero(ExtZero), .ALU_Control(ALU_Control), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   vec_t act;
   assign act = {state, CPU_MIO, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
                 ALUSrcA, ALUSrcB, ExtZero, ALU_Control, RegDst, MemtoReg, RegWrite, illegal};

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t exp_q[$];
   ent_t tbl[$];

   task automatic check(input string name, input vec_t got, input vec_t want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got=%07h (state %0d) want=%07h (state %0d)",
                    name, got, got.st, want, want.st);
   endtask

   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         check($sformatf("cycle@%0t", $time), act, e);
      end
   end

   function automatic vec_t base(input int st);
      vec_t v;
      v     = '0;
      v.st  = st[4:0];
      v.alu = 3'b010;
      return v;
   endfunction

   function automatic vec_t fetch_vec(input logic rdy);
      vec_t v;
      v           = base(0);
      v.cpu_mio   = 1'b1;
      v.mem_read  = 1'b1;
      v.alu_src_b = 2'b01;
      v.pc_write  = rdy;
      v.ir_write  = rdy;
      return v;
   endfunction

   task automatic step(input logic rdy, input logic z, input vec_t e);
      MIO_ready = rdy;
      zero      = z;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic add_ent(input logic [5:0] op, input logic [5:0] fun, input kind_t k,
                          input logic [2:0] alu, input logic ez, input logic lui);
      ent_t e;
      e.op = op; e.fun = fun; e.k = k; e.alu = alu; e.ez = ez; e.lui = lui;
      tbl.push_back(e);
   endtask

   // One whole instruction: fetch (with stalls), decode, then the class-specific tail.
   task automatic run_instr(input ent_t e, input int if_stall, input int mem_stall, input int zsel);
      vec_t v;
      logic z;
      for (int i = 0; i < if_stall; i++) begin
         OPcode = 6'($urandom);
         step(1'b0, 1'($urandom), fetch_vec(1'b0));
      end
      OPcode = 6'($urandom);
      step(1'b1, 1'($urandom), fetch_vec(1'b1));
      OPcode = e.op;
      Fun    = (e.k inside {K_R, K_JR, K_JALR, K_ILL}) ? e.fun : 6'($urandom);
      v = base(1); v.alu_src_b = 2'b11;
      step(1'($urandom), 1'($urandom), v);
      case (e.k)
         K_R: begin
            v = base(6); v.alu_src_a = 1'b1; v.alu = e.alu;
            step(1'($urandom), 1'($urandom), v);
            v = base(7); v.reg_dst = 2'b01; v.reg_write = 1'b1;
            step(1'($urandom), 1'($urandom), v);
         end
         K_LW, K_SW: begin
            v = base(2); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
            step(1'($urandom), 1'($urandom), v);
            v = base(e.k == K_LW ? 3 : 5);
            v.cpu_mio = 1'b1; v.iord = 1'b1;
            if (e.k == K_LW) v.mem_read = 1'b1; else v.mem_write = 1'b1;
            for (int i = 0; i < mem_stall; i++) step(1'b0, 1'($urandom), v);
            step(1'b1, 1'($urandom), v);
            if (e.k == K_LW) begin
               v = base(4); v.mem_to_reg = 2'b01; v.reg_write = 1'b1;
               step(1'($urandom), 1'($urandom), v);
            end
         end
         K_BEQ, K_BNE: begin
            z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
            v = base(8); v.alu_src_a = 1'b1; v.alu = 3'b110; v.pc_source = 2'b01;
            v.pc_write = (e.k == K_BEQ) ? z : ~z;
            step(1'($urandom), z, v);
         end
         K_J, K_JAL: begin
            v = base(e.k == K_J ? 9 : 10); v.pc_source = 2'b10; v.pc_write = 1'b1;
            if (e.k == K_JAL) begin
               v.reg_dst = 2'b10; v.mem_to_reg = 2'b10; v.reg_write = 1'b1;
            end
            step(1'($urandom), 1'($urandom), v);
         end
         K_JR, K_JALR: begin
            v = base(e.k == K_JR ? 11 : 12); v.pc_source = 2'b11; v.pc_write = 1'b1;
            if (e.k == K_JALR) begin
               v.reg_dst = 2'b01; v.mem_to_reg = 2'b10; v.reg_write = 1'b1;
            end
            step(1'($urandom), 1'($urandom), v);
         end
         K_I: begin
            v = base(13); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
            v.alu = e.alu; v.ext_zero = e.ez;
            step(1'($urandom), 1'($urandom), v);
            v = base(14); v.reg_write = 1'b1; v.mem_to_reg = e.lui ? 2'b11 : 2'b00;
            step(1'($urandom), 1'($urandom), v);
         end
         default: begin
            v = base(15); v.illegal = 1'b1;
            step(1'($urandom), 1'($urandom), v);
         end
      endcase
   endtask

   function automatic ent_t find(input kind_t k, input logic [5:0] op);
      foreach (tbl[i]) if (tbl[i].k == k && tbl[i].op == op) return tbl[i];
      return tbl[0];
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t rv, v;
      ent_t sw_e, ill_e;
      add_ent(6'h00, 6'b100000, K_R, 3'b010, 0, 0);
      add_ent(6'h00, 6'b100010, K_R, 3'b110, 0, 0);
      add_ent(6'h00, 6'b100100, K_R, 3'b000, 0, 0);
      add_ent(6'h00, 6'b100101, K_R, 3'b001, 0, 0);
      add_ent(6'h00, 6'b100110, K_R, 3'b011, 0, 0);
      add_ent(6'h00, 6'b100111, K_R, 3'b100, 0, 0);
      add_ent(6'h00, 6'b101010, K_R, 3'b111, 0, 0);
      add_ent(6'h00, 6'b000010, K_R, 3'b101, 0, 0);
      add_ent(6'h00, 6'b001000, K_JR, 3'b010, 0, 0);
      add_ent(6'h00, 6'b001001, K_JALR, 3'b010, 0, 0);
      add_ent(6'b100011, 6'h00, K_LW, 3'b010, 0, 0);
      add_ent(6'b101011, 6'h00, K_SW, 3'b010, 0, 0);
      add_ent(6'b000100, 6'h00, K_BEQ, 3'b110, 0, 0);
      add_ent(6'b000101, 6'h00, K_BNE, 3'b110, 0, 0);
      add_ent(6'b000010, 6'h00, K_J, 3'b010, 0, 0);
      add_ent(6'b000011, 6'h00, K_JAL, 3'b010, 0, 0);
      add_ent(6'b001000, 6'h00, K_I, 3'b010, 0, 0);
      add_ent(6'b001010, 6'h00, K_I, 3'b111, 0, 0);
      add_ent(6'b001100, 6'h00, K_I, 3'b000, 1, 0);
      add_ent(6'b001101, 6'h00, K_I, 3'b001, 1, 0);
      add_ent(6'b001110, 6'h00, K_I, 3'b011, 1, 0);
      add_ent(6'b001111, 6'h00, K_I, 3'b010, 0, 1);

      // reset: fetch-state selects, all strobes held low even with MIO_ready=1
      rv = fetch_vec(1'b0);
      rv.mem_read = 1'b0;
      #12;
      check("reset_state", act, rv);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed plan items
      run_instr(tbl[0], 0, 0, -1);                       // add
      run_instr(find(K_LW, 6'b100011), 0, 3, -1);        // lw, 3 wait cycles
      run_instr(find(K_BEQ, 6'b000100), 0, 0, 1);
      run_instr(find(K_BEQ, 6'b000100), 0, 0, 0);
      run_instr(find(K_BNE, 6'b000101), 0, 0, 1);
      run_instr(find(K_BNE, 6'b000101), 0, 0, 0);
      run_instr(find(K_JAL, 6'b000011), 0, 0, -1);
      run_instr(tbl[0], 5, 0, -1);                       // 5-cycle fetch stall

      for (int n = 0; n < 60; n++)
         run_instr(tbl[$urandom_range(tbl.size() - 1)], $urandom_range(2),
                   $urandom_range(3), -1);

      // abort a stalled store with reset
      sw_e = find(K_SW, 6'b101011);
      OPcode = 6'($urandom);
      step(1'b1, 1'b0, fetch_vec(1'b1));
      OPcode = sw_e.op;
      v = base(1); v.alu_src_b = 2'b11;
      step(1'b0, 1'b0, v);
      v = base(2); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
      step(1'b0, 1'b0, v);
      v = base(5); v.cpu_mio = 1'b1; v.iord = 1'b1; v.mem_write = 1'b1;
      step(1'b0, 1'b0, v);
      MIO_ready = 1'b0;
      #2;
      check("mem_wr_stalled", act, v);
      rst_n = 1'b0;
      #1;
      check("reset_mid_mem_wr", act, rv);
      MIO_ready = 1'b1;
      @(posedge clk); #1;
      check("reset_held", act, rv);
      MIO_ready = 1'b0;
      rst_n = 1'b1;
      run_instr(tbl[1], 1, 0, -1);

      // unsupported opcode: ILLEGAL must stick
      ill_e.op = 6'h10; ill_e.fun = 6'($urandom); ill_e.k = K_ILL;
      ill_e.alu = 3'b010; ill_e.ez = 1'b0; ill_e.lui = 1'b0;
      run_instr(ill_e, 0, 0, -1);
      v = base(15); v.illegal = 1'b1;
      for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom), v);

      @(negedge clk); #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core. It replaces single-cycle decode by sequencing the shared ALU, the unified instruction/data memory port and the register file over 3–5 states per instruction.
- It stalls on the memory/IO ready handshake.
- It sits beside the multi-cycle datapath, and its OPcode/Fun inputs come from that datapath's IR.
- ALU_Control codes match the existing ALU: and 000, or 001, add 010, xor 011, nor 100, srl 101, sub 110, slt 111.

Parameters:
- ILLEGAL_HALT, 1. When 1, the ILLEGAL state is sticky until reset. When 0, ILLEGAL returns to IF after one cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OPcode  in  6  IR[31:26]; stable in every state except IF.
- Fun  in  6  IR[5:0].
- zero  in  1  ALU zero flag, same cycle.
- MIO_ready  in  1  memory/IO access complete.
- CPU_MIO  out  1  memory/IO access request.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  IR load enable.
- PCWrite  out  1  PC load enable.
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 rt, 01 const 4, 10 extended immediate, 11 sign-extended immediate << 2.
- ExtZero  out  1  1 = zero-extend immediate.
- ALU_Control  out  3  ALU operation.
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC, 11 {imm,16'b0}.
- RegWrite  out  1  register file write enable.
- illegal  out  1  unsupported instruction decoded.
- state  out  5  current state, for debug.

Behaviour:
- Output style: Moore outputs decoded from the state register. The only exceptions are PCWrite/IRWrite in IF and PCWrite in BR, which also depend on MIO_ready or zero.
- Reset: while rst_n=0, state=IF asynchronously. MemRead, MemWrite, IRWrite, PCWrite and RegWrite are forced 0, illegal=0, and all other outputs take IF values. The first fetch occurs on the first edge after release.
- Unlisted outputs: 0, with ALU_Control=010.
- States (encoding 0–15) and transitions:
  - IF (0): CPU_MIO=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add. PCWrite=IRWrite=MIO_ready. Goes to ID when MIO_ready=1, else holds.
  - ID (1): ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Dispatch:
    - R-type with Fun in {add, sub, and, or, slt, nor, srl, xor} → EX_R.
    - Fun 001000 → JR; Fun 001001 → JALR.
    - lw/sw → MEM_ADDR; beq/bne → BR.
    - j → J; jal → JAL.
    - addi/slti/andi/ori/xori/lui → EX_I.
    - Anything else → ILLEGAL.
  - MEM_ADDR (2): ALUSrcA=1, ALUSrcB=10, add. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD (3): CPU_MIO=1, MemRead=1, IorD=1. Holds until MIO_ready, then → WB_LW.
  - WB_LW (4): RegDst=00, MemtoReg=01, RegWrite=1. → IF.
  - MEM_WR (5): CPU_MIO=1, MemWrite=1, IorD=1. Holds until MIO_ready, then → IF. MemWrite stays asserted for the whole stall.
  - EX_R (6): ALUSrcA=1, ALUSrcB=00, ALU_Control from Fun. → WB_R.
  - WB_R (7): RegDst=01, MemtoReg=00, RegWrite=1. → IF.
  - BR (8): ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCWrite=(beq&zero)|(bne&~zero). → IF.
  - J (9): PCSource=10, PCWrite=1. → IF.
  - JAL (10): J outputs plus RegDst=10, MemtoReg=10, RegWrite=1. The PC already holds PC+4. → IF.
  - JR (11): PCSource=11, PCWrite=1. → IF.
  - JALR (12): JR outputs plus RegDst=01, MemtoReg=10, RegWrite=1. The link value is the old PC+4. → IF.
  - EX_I (13): ALUSrcA=1, ALUSrcB=10.
    - addi add, slti slt, andi and, ori or, xori xor, lui add.
    - ExtZero=1 for andi/ori/xori.
    - → WB_I.
  - WB_I (14): RegDst=00, RegWrite=1, MemtoReg=11 for lui, else 00. → IF.
  - ILLEGAL (15): all enables 0, illegal=1. Holds if ILLEGAL_HALT, else → IF.
- Stall rules: a MIO_ready stall never advances the PC or IR. MIO_ready is ignored outside IF, MEM_RD and MEM_WR.
- CPI: R/I 4, lw 5, sw 4, branch/jump 3, plus wait cycles.
- Mid-operation reset: an asynchronous abort from any state, including a stalled MEM_WR; MemWrite drops immediately.

Decomposition:
- mcpu_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - ALU_Control codes;
  - PCSource, ALUSrcB, RegDst and MemtoReg select codes.
- One sub-module, mcpu_decode: combinational (OPcode, Fun) → next-state dispatch class and ALU_Control. The FSM register and output decode live in mcpu_ctrl.

Test Plan:
- add (OPcode 0, Fun 100000), MIO_ready=1 → state trace 0,1,6,7,0; ALU_Control=010 in EX_R; RegWrite=1 and RegDst=01 only in WB_R.
- lw (100011) with MIO_ready low for 3 cycles in MEM_RD → state 3 held 4 cycles, CPU_MIO=MemRead=IorD=1 throughout, RegWrite=0, then WB_LW with MemtoReg=01.
- beq (000100): zero=1 → PCWrite=1, PCSource=01 in BR; repeat with zero=0 → PCWrite=0. bne gives the inverse.
- jal (000011) → trace 0,1,10,0; RegDst=10, MemtoReg=10, PCSource=10, PCWrite=RegWrite=1 in JAL.
- MIO_ready=0 in IF for 5 cycles → PCWrite=IRWrite=0 each cycle; on MIO_ready=1 both pulse for 1 cycle and the state moves to 1.
- OPcode 6'h10 → ILLEGAL, illegal=1 sticky. Separately, rst_n low mid-MEM_WR → MemWrite=0 immediately, state=0 and held until release.
